button_pulse_repeat: RTL and testbench

//  Upstream conditioning stage for the push-button-driven BCD counters on the 7-segment display path.
//  - Synchronises and debounces one raw button.
//  - Emits a 1-cycle press pulse on each clean press.
//  - While the button is held, emits typematic auto-repeat pulses.
//  - Emits a 1-cycle release pulse on each clean release.
//  The counter logic consumes o_Press_Pulse directly as its increment strobe and needs no edge detector.

---
 rtl/button_pulse_repeat_pkg.sv | 26 ++
 rtl/button_pulse_repeat_if.sv | 29 ++
 rtl/button_pulse_repeat_debounce_filter.sv | 54 +++++
 rtl/button_pulse_repeat.sv | 101 ++++++++++
 tb/tb_button_pulse_repeat.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/button_pulse_repeat_pkg.sv
`default_nettype none
// ==========================================================================
// button_pulse_repeat_pkg : shared FSM encoding and 25 MHz button timing
// Rev 1.0
// ==========================================================================
package button_pulse_repeat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  localparam int c_CLK_HZ         = 25_000_000;
  localparam int c_DEBOUNCE_LIMIT = c_CLK_HZ / 100;  // 10 ms
  localparam int c_HOLD_LIMIT     = c_CLK_HZ / 2;    // 500 ms
  localparam int c_REPEAT_LIMIT   = c_CLK_HZ / 10;   // 100 ms

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_pulse_repeat_if.sv
`default_nettype none
// ==========================================================================
// button_pulse_repeat_if : raw button in, conditioned level and strobes out
// Rev 1.0
// ==========================================================================
interface button_pulse_repeat_if;
  logic i_Switch;
  logic o_Switch;
  logic o_Press_Pulse;
  logic o_Release_Pulse;
  logic o_Repeat_Active;

  modport master (
    output i_Switch,
    input  o_Switch,
    input  o_Press_Pulse,
    input  o_Release_Pulse,
    input  o_Repeat_Active
  );

  modport slave (
    input  i_Switch,
    output o_Switch,
    output o_Press_Pulse,
    output o_Release_Pulse,
    output o_Repeat_Active
  );
endinterface
`default_nettype wire

// File: rtl/button_pulse_repeat_debounce_filter.sv
`default_nettype none
// ==========================================================================
// debounce_filter : 2-flop synchroniser plus stability counter on one button
// Rev 1.0
// ==========================================================================
module debounce_filter #(
  parameter int DEBOUNCE_LIMIT = 4,
  parameter int CNT_W          = 2
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Rise,
  output logic o_Fall
);
  logic             r_sync1;
  logic             r_sync2;
  logic             r_state;
  logic [CNT_W-1:0] r_count;
  logic             w_diff;
  logic             w_expire;

  assign w_diff   = (r_sync2 != r_state);
  assign w_expire = w_diff && (r_count == CNT_W'(DEBOUNCE_LIMIT - 1));

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= 1'b0;
      r_count <= '0;
    end else begin
      r_sync1 <= i_Switch;
      r_sync2 <= r_sync1;
      if (w_expire) begin
        r_state <= ~r_state;
        r_count <= '0;
      end else if (w_diff) begin
        r_count <= r_count + 1'b1;
      end else begin
        r_count <= '0;
      end
    end
  end

  // Edge strobes announce the toggle one edge early so the FSM can register
  // its pulse in the same cycle o_Switch changes.
  assign o_Switch = r_state;
  assign o_Rise   = w_expire & ~r_state;
  assign o_Fall   = w_expire &  r_state;

endmodule
`default_nettype wire

// File: rtl/button_pulse_repeat.sv
`default_nettype none
// ==========================================================================
// button_pulse_repeat : debounced button with press, repeat and release strobes
// Rev 1.0
// ==========================================================================
module button_pulse_repeat
  import button_pulse_repeat_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = c_DEBOUNCE_LIMIT,
  parameter int HOLD_LIMIT     = c_HOLD_LIMIT,
  parameter int REPEAT_LIMIT   = c_REPEAT_LIMIT
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  button_pulse_repeat_if.slave bus
);
  localparam int c_CNT_W = $clog2(max3(DEBOUNCE_LIMIT, HOLD_LIMIT, REPEAT_LIMIT));

  logic               w_switch;
  logic               w_rise;
  logic               w_fall;
  state_t             r_state;
  logic [c_CNT_W-1:0] r_timer;
  logic               r_press;
  logic               r_release;
  logic               r_repeat;

  debounce_filter #(
    .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
    .CNT_W          (c_CNT_W)
  ) u_filter (
    .i_Clk    (i_Clk),
    .i_Rst_L  (i_Rst_L),
    .i_Switch (bus.i_Switch),
    .o_Switch (w_switch),
    .o_Rise   (w_rise),
    .o_Fall   (w_fall)
  );

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_press <= 1'b1;
            r_timer <= '0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Release takes priority over a coincident hold expiry.
          if (w_fall) begin
            r_release <= 1'b1;
            r_timer   <= '0;
            r_state   <= ST_IDLE;
          end else if (r_timer == c_CNT_W'(HOLD_LIMIT - 1)) begin
            r_press  <= 1'b1;
            r_timer  <= '0;
            r_repeat <= 1'b1;
            r_state  <= ST_REPEAT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (w_fall) begin
            r_release <= 1'b1;
            r_timer   <= '0;
            r_repeat  <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (r_timer == c_CNT_W'(REPEAT_LIMIT - 1)) begin
            r_press <= 1'b1;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_timer  <= '0;
          r_repeat <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_Switch        = w_switch;
  assign bus.o_Press_Pulse   = r_press;
  assign bus.o_Release_Pulse = r_release;
  assign bus.o_Repeat_Active = r_repeat;

endmodule
`default_nettype wire

// File: tb/tb_button_pulse_repeat.sv
`default_nettype none
// ==========================================================================
// tb_button_pulse_repeat : directed scenarios plus random presses vs a model
// Rev 1.0
// ==========================================================================
module tb_button_pulse_repeat;
  localparam int DL = 4;
  localparam int HL = 10;
  localparam int RL = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  button_pulse_repeat_if bus ();

  button_pulse_repeat #(
    .DEBOUNCE_LIMIT (DL),
    .HOLD_LIMIT     (HL),
    .REPEAT_LIMIT   (RL)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int t0          = 0;
  int press_q[$];
  int rel_q[$];
  int rep_q[$];

  // Reference: sync = raw delayed two edges; level flips once the last DL
  // synced samples all disagree with it; pulses follow from time since press.
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_sw = 1'b0;
  logic m_hist [DL];
  int   m_rise = 0;
  logic m_press = 1'b0, m_rel = 1'b0, m_rep = 1'b0;

  task automatic model_step(input logic raw, input logic rst_ok);
    logic flip;
    logic prev;
    int   d;
    if (!rst_ok) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_sw = 1'b0;
      for (int i = 0; i < DL; i++) m_hist[i] = 1'b0;
      m_press = 1'b0; m_rel = 1'b0; m_rep = 1'b0;
    end else begin
      for (int i = DL - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = m_s2;
      flip = 1'b1;
      for (int i = 0; i < DL; i++) if (m_hist[i] == m_sw) flip = 1'b0;
      m_s2 = m_s1;
      m_s1 = raw;
      prev = m_sw;
      if (flip) m_sw = ~m_sw;
      m_press = 1'b0; m_rel = 1'b0; m_rep = 1'b0;
      if (m_sw && !prev) begin
        m_press = 1'b1;
        m_rise  = cyc;
      end else if (!m_sw && prev) begin
        m_rel = 1'b1;
      end else if (m_sw) begin
        d       = cyc - m_rise;
        m_press = (d == HL) || (d > HL && ((d - HL) % RL) == 0);
        m_rep   = (d >= HL);
      end
    end
  endtask

  initial for (int i = 0; i < DL; i++) m_hist[i] = 1'b0;

  always @(posedge clk) begin
    logic raw_e;
    logic rst_e;
    raw_e = bus.i_Switch;
    rst_e = rst_n;
    #1;
    cyc++;
    model_step(raw_e, rst_e);
    vectors++;
    if ({bus.o_Switch, bus.o_Press_Pulse, bus.o_Release_Pulse, bus.o_Repeat_Active} !==
        {m_sw, m_press, m_rel, m_rep}) begin
      miscompares++;
      $display("FAIL cycle %0d sw/press/rel/rep got %b%b%b%b exp %b%b%b%b", cyc,
               bus.o_Switch, bus.o_Press_Pulse, bus.o_Release_Pulse, bus.o_Repeat_Active,
               m_sw, m_press, m_rel, m_rep);
    end
    if (bus.o_Press_Pulse === 1'b1)   press_q.push_back(cyc - t0);
    if (bus.o_Release_Pulse === 1'b1) rel_q.push_back(cyc - t0);
    if (bus.o_Repeat_Active === 1'b1) rep_q.push_back(cyc - t0);
  end

  task automatic drive(input logic v, input int n);
    bus.i_Switch = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic begin_scn();
    t0 = cyc;
    press_q.delete();
    rel_q.delete();
    rep_q.delete();
  endtask

  task automatic check_q(input string name, input int got[$], input int exp[$]);
    int bad;
    bad = (got.size() != exp.size()) ? 0 : -1;
    if (bad < 0)
      for (int i = 0; i < exp.size(); i++)
        if (bad < 0 && got[i] != exp[i]) bad = i;
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL %s size got %0d exp %0d, index %0d got %0d exp %0d", name,
               got.size(), exp.size(), bad,
               (bad < got.size()) ? got[bad] : -1, (bad < exp.size()) ? exp[bad] : -1);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  int exp_p[$];
  int exp_r[$];
  int len;

  initial begin
    bus.i_Switch = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_int("reset_outputs",
              int'({bus.o_Switch, bus.o_Press_Pulse, bus.o_Release_Pulse, bus.o_Repeat_Active}), 0);
    rst_n = 1'b1;
    drive(1'b0, 4);

    // Short glitch is filtered completely
    begin_scn(); drive(1'b1, 3); drive(1'b0, 15);
    exp_p = {}; exp_r = {};
    check_q("glitch_press", press_q, exp_p);
    check_q("glitch_release", rel_q, exp_r);

    // Short press: one press, one release, no repeat
    begin_scn(); drive(1'b1, 8); drive(1'b0, 14);
    exp_p = '{6}; exp_r = '{14};
    check_q("tap_press", press_q, exp_p);
    check_q("tap_release", rel_q, exp_r);
    check_int("tap_repeat_cycles", rep_q.size(), 0);

    // Long hold; release lands on the cycle the next repeat would fire
    begin_scn(); drive(1'b1, 37); drive(1'b0, 14);
    exp_p = '{6, 16, 19, 22, 25, 28, 31, 34, 37, 40}; exp_r = '{43};
    check_q("hold_press", press_q, exp_p);
    check_q("hold_release", rel_q, exp_r);
    check_int("hold_repeat_first", (rep_q.size() > 0) ? rep_q[0] : -1, 16);
    check_int("hold_repeat_cycles", rep_q.size(), 27);

    // Chatter for 20 cycles then steady high
    begin_scn();
    for (int i = 0; i < 5; i++) begin drive(1'b1, 2); drive(1'b0, 2); end
    drive(1'b1, 8); drive(1'b0, 14);
    exp_p = '{26}; exp_r = '{34};
    check_q("chatter_press", press_q, exp_p);
    check_q("chatter_release", rel_q, exp_r);

    // Reset in REPEAT with the button still held: re-qualified press only
    begin_scn(); drive(1'b1, 20);
    rst_n = 1'b0; drive(1'b1, 2);
    rst_n = 1'b1; drive(1'b1, 4); drive(1'b0, 14);
    exp_p = '{6, 16, 19, 28}; exp_r = '{32};
    check_q("reset_hold_press", press_q, exp_p);
    check_q("reset_hold_release", rel_q, exp_r);

    // Release coincides with hold-timer expiry
    begin_scn(); drive(1'b1, 10); drive(1'b0, 14);
    exp_p = '{6}; exp_r = '{16};
    check_q("expiry_press", press_q, exp_p);
    check_q("expiry_release", rel_q, exp_r);
    check_int("expiry_repeat_cycles", rep_q.size(), 0);

    // Random runs with occasional resets, checked against the model every cycle
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 1'b0;
        drive(bus.i_Switch, $urandom_range(1, 2));
        rst_n = 1'b1;
      end
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 6);
      drive(logic'($urandom_range(0, 1)), len);
    end
    drive(1'b0, 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
